// File: rtl/key_debounce.sv
// Push-button debouncer with press/release pulses and an optional long-press pulse.
// key_in (low = pressed) is synchronised, filtered through a four-state FSM and
// turned into a debounced level plus one-cycle event pulses.
// Optional feature: define KEY_LONG_PRESS_EN to enable the key_long pulse; when it
// is undefined key_long is tied low and the hold counter saturates at DEB_CNT-1.
// Parameters must satisfy DEB_CNT >= 2 and LONG_CNT > DEB_CNT.
module key_debounce #(
    parameter int DEB_CNT  = 1000000,
    parameter int LONG_CNT = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_FILT = 2'd1,
        DOWN       = 2'd2,
        REL_FILT   = 2'd3
    } state_t;

    // The shared counter must hold max(DEB_CNT, LONG_CNT)-1.
    localparam int CNT_MAX = (DEB_CNT > LONG_CNT) ? DEB_CNT : LONG_CNT;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CNT - 1);
`ifdef KEY_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CNT - 1);
`else
    localparam logic [CNT_W-1:0] HOLD_LAST = DEB_LAST;
`endif

    logic [1:0]       sync_q, sync_d;
    logic             key_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_state_q, key_state_d;
    logic             key_press_q, key_press_d;
    logic             key_release_q, key_release_d;

    // Two-flop synchroniser shift: key_in enters bit 0, key_s leaves bit 1.
    always_comb begin
        sync_d = {sync_q[0], key_in};
    end

    assign key_s = sync_q[1];

    // Synchroniser flops; idle (released) level is 1 so reset looks like no press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so every
            // flop samples the pre-edge value of its inputs, whatever the order.
            sync_q <= sync_d;
        end
    end

    // Next-state, counter and registered-output logic of the debounce FSM.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path through
        // the case statement can leave a signal unassigned and infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        key_press_d   = 1'b0;
        key_release_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!key_s) begin
                    state_d = PRESS_FILT;
                    cnt_d   = '0;
                end
            end
            PRESS_FILT: begin
                if (key_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d     = DOWN;
                    cnt_d       = '0;
                    key_press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (key_s) begin
                    state_d = REL_FILT;
                    cnt_d   = '0;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REL_FILT: begin
                if (!key_s) begin
                    // Bounce while releasing: back to DOWN and restart the hold count.
                    state_d = DOWN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d       = IDLE;
                    cnt_d         = '0;
                    key_release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        key_state_d = (state_d == DOWN) || (state_d == REL_FILT);
    end

    // FSM state, counter and event/level output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            key_state_q   <= 1'b0;
            key_press_q   <= 1'b0;
            key_release_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_state_q   <= key_state_d;
            key_press_q   <= key_press_d;
            key_release_q <= key_release_d;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic long_done_q, long_done_d;
    logic key_long_q, key_long_d;

    // Long-press detect: fire once per press, the cycle after the hold count tops out.
    always_comb begin
        long_done_d = long_done_q;
        key_long_d  = 1'b0;
        if (state_q == IDLE) begin
            long_done_d = 1'b0;
        end else if ((state_q == DOWN) && (cnt_q == HOLD_LAST) && !long_done_q) begin
            key_long_d  = 1'b1;
            long_done_d = 1'b1;
        end
    end

    // Long-press flag and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            long_done_q <= 1'b0;
            key_long_q  <= 1'b0;
        end else begin
            long_done_q <= long_done_d;
            key_long_q  <= key_long_d;
        end
    end

    assign key_long = key_long_q;
`else
    assign key_long = 1'b0;
`endif

    assign key_state   = key_state_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEB_CNT=8, LONG_CNT=32 and a 20 ns clock.
// Inputs change on the falling edge and outputs are sampled on the falling edge.
// Long-press expectations follow KEY_LONG_PRESS_EN when the bench is built.
module tb_key_debounce;

    localparam int DEB_CNT  = 8;
    localparam int LONG_CNT = 32;
`ifdef KEY_LONG_PRESS_EN
    localparam int EXP_LONG = 1;
`else
    localparam int EXP_LONG = 0;
`endif

    logic clk;
    logic rst_n;
    logic key_in;
    logic key_state;
    logic key_press;
    logic key_release;
    logic key_long;

    int checks;
    int errors;
    int press_seen;
    int rel_seen;
    int long_seen;
    int state_hi_seen;
    int overlap_seen;

    key_debounce #(
        .DEB_CNT (DEB_CNT),
        .LONG_CNT(LONG_CNT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Advance n clocks, ending on a falling edge, and tally the observed pulses.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            if (key_press === 1'b1)   press_seen++;
            if (key_release === 1'b1) rel_seen++;
            if (key_long === 1'b1)    long_seen++;
            if (key_state === 1'b1)   state_hi_seen++;
            if ((int'(key_press) + int'(key_release) + int'(key_long)) > 1) overlap_seen++;
        end
    endtask

    task automatic clear_tallies();
        press_seen    = 0;
        rel_seen      = 0;
        long_seen     = 0;
        state_hi_seen = 0;
        overlap_seen  = 0;
    endtask

    task automatic test_reset();
        logic [3:0] seen;
        seen = 4'b0;
        rst_n  = 1'b0;
        key_in = 1'b1;
        repeat (50) begin
            @(negedge clk);
            seen |= {key_state, key_press, key_release, key_long};
        end
        checks++;
        if (seen !== 4'b0) begin
            errors++;
            $display("FAIL reset_hold outputs_or=%b expected=%b", seen, 4'b0);
        end
        rst_n = 1'b1;
        seen  = 4'b0;
        repeat (100) begin
            @(negedge clk);
            seen |= {key_state, key_press, key_release, key_long};
        end
        checks++;
        if (seen !== 4'b0) begin
            errors++;
            $display("FAIL reset_idle outputs_or=%b expected=%b", seen, 4'b0);
        end
    endtask

    task automatic test_press();
        clear_tallies();
        key_in = 1'b0;
        step(10);
        checks++;
        if ({key_press, key_state} !== 2'b00) begin
            errors++;
            $display("FAIL press_early press/state=%b expected=%b", {key_press, key_state}, 2'b00);
        end
        step(1);
        checks++;
        if ({key_press, key_state} !== 2'b11) begin
            errors++;
            $display("FAIL press_edge11 press/state=%b expected=%b", {key_press, key_state}, 2'b11);
        end
        step(1);
        checks++;
        if ({key_press, key_state} !== 2'b01) begin
            errors++;
            $display("FAIL press_one_cycle press/state=%b expected=%b", {key_press, key_state}, 2'b01);
        end
        step(8);
        key_in = 1'b1;
        step(10);
        checks++;
        if ({key_release, key_state} !== 2'b01) begin
            errors++;
            $display("FAIL release_early release/state=%b expected=%b", {key_release, key_state}, 2'b01);
        end
        step(1);
        checks++;
        if ({key_release, key_state} !== 2'b10) begin
            errors++;
            $display("FAIL release_edge11 release/state=%b expected=%b", {key_release, key_state}, 2'b10);
        end
        step(1);
        checks++;
        if (key_release !== 1'b0) begin
            errors++;
            $display("FAIL release_one_cycle release=%b expected=0", key_release);
        end
        step(10);
    endtask

    task automatic test_glitch();
        clear_tallies();
        key_in = 1'b0; step(1);
        key_in = 1'b1; step(2);
        key_in = 1'b0; step(3);
        key_in = 1'b1; step(2);
        key_in = 1'b0; step(7);
        key_in = 1'b1; step(2);
        step(20);
        checks++;
        if (press_seen !== 0) begin
            errors++;
            $display("FAIL glitch_press press_count=%0d expected=0", press_seen);
        end
        checks++;
        if (state_hi_seen !== 0) begin
            errors++;
            $display("FAIL glitch_state state_high_cycles=%0d expected=0", state_hi_seen);
        end
    endtask

    task automatic test_bounce();
        clear_tallies();
        key_in = 1'b0; step(20);
        key_in = 1'b1; step(3);
        key_in = 1'b0; step(4);
        key_in = 1'b1;
        step(10);
        checks++;
        if ({key_release, key_state} !== 2'b01) begin
            errors++;
            $display("FAIL bounce_early release/state=%b expected=%b", {key_release, key_state}, 2'b01);
        end
        step(1);
        checks++;
        if ({key_release, key_state} !== 2'b10) begin
            errors++;
            $display("FAIL bounce_fall release/state=%b expected=%b", {key_release, key_state}, 2'b10);
        end
        step(10);
        checks++;
        if (press_seen !== 1) begin
            errors++;
            $display("FAIL bounce_press_count got=%0d expected=1", press_seen);
        end
        checks++;
        if (rel_seen !== 1) begin
            errors++;
            $display("FAIL bounce_release_count got=%0d expected=1", rel_seen);
        end
    endtask

    task automatic test_long();
        clear_tallies();
        key_in = 1'b0;
        step(11);
        checks++;
        if (key_press !== 1'b1) begin
            errors++;
            $display("FAIL long_press press=%b expected=1", key_press);
        end
        step(31);
        checks++;
        if (key_long !== 1'b0) begin
            errors++;
            $display("FAIL long_early long=%b expected=0", key_long);
        end
        step(1);
        checks++;
        if (key_long !== 1'(EXP_LONG)) begin
            errors++;
            $display("FAIL long_at_32 long=%b expected=%0d", key_long, EXP_LONG);
        end
        step(17);
        checks++;
        if (long_seen !== EXP_LONG) begin
            errors++;
            $display("FAIL long_count got=%0d expected=%0d", long_seen, EXP_LONG);
        end
        key_in = 1'b1;
        step(20);
        checks++;
        if ({press_seen, rel_seen, long_seen} !== {32'sd1, 32'sd1, 32'(EXP_LONG)}) begin
            errors++;
            $display("FAIL long_totals press=%0d release=%0d long=%0d expected=1/1/%0d",
                     press_seen, rel_seen, long_seen, EXP_LONG);
        end
        checks++;
        if (overlap_seen !== 0) begin
            errors++;
            $display("FAIL pulse_overlap cycles=%0d expected=0", overlap_seen);
        end
    endtask

    task automatic test_reset_mid_press();
        clear_tallies();
        key_in = 1'b0;
        step(16);
        checks++;
        if (key_state !== 1'b1) begin
            errors++;
            $display("FAIL midrst_held state=%b expected=1", key_state);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({key_state, key_press, key_release, key_long} !== 4'b0) begin
            errors++;
            $display("FAIL midrst_async outputs=%b expected=%b",
                     {key_state, key_press, key_release, key_long}, 4'b0);
        end
        step(3);
        clear_tallies();
        rst_n = 1'b1;
        step(10);
        checks++;
        if ({key_press, key_state} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_early press/state=%b expected=%b", {key_press, key_state}, 2'b00);
        end
        step(1);
        checks++;
        if ({key_press, key_state} !== 2'b11) begin
            errors++;
            $display("FAIL midrst_repress press/state=%b expected=%b", {key_press, key_state}, 2'b11);
        end
        checks++;
        if (rel_seen !== 0) begin
            errors++;
            $display("FAIL midrst_no_release release_count=%0d expected=0", rel_seen);
        end
        key_in = 1'b1;
        step(20);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        clear_tallies();
        rst_n  = 1'b0;
        key_in = 1'b1;
        test_reset();
        test_press();
        test_glitch();
        test_bounce();
        test_long();
        test_reset_mid_press();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_debounce.md
KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter DEB_CNT, default 1000000, is the debounce window in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter LONG_CNT, default 50000000, is the long-press threshold in clk cycles (1 s at 50 MHz).
REQ-003 Port clk, input, 1 bit: system clock, rising-edge active.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port key_in, input, 1 bit: raw push-button, asynchronous to clk, low = pressed.
REQ-006 Port key_state, output, 1 bit: debounced level, 1 = pressed.
REQ-007 Port key_press, output, 1 bit: one-cycle pulse on each accepted press.
REQ-008 Port key_release, output, 1 bit: one-cycle pulse on each accepted release.
REQ-009 Port key_long, output, 1 bit: one-cycle pulse when a press has been held for LONG_CNT cycles.

Function
REQ-010 key_in SHALL pass through a two-flop synchronizer; the second flop output (key_s) is the only key_in-derived signal used.
REQ-011 The FSM SHALL have states IDLE, PRESS_FILT, DOWN and REL_FILT, with a shared counter sized to hold max(DEB_CNT, LONG_CNT)-1.
REQ-012 IDLE: if key_s=0, go to PRESS_FILT with counter=0; otherwise stay.
REQ-013 PRESS_FILT: key_s=1 -> IDLE, counter cleared; key_s=0 and counter=DEB_CNT-1 -> DOWN, counter cleared; otherwise counter+1.
REQ-014 DOWN: key_s=1 -> REL_FILT, counter cleared; otherwise counter increments, saturating at LONG_CNT-1.
REQ-015 REL_FILT: key_s=0 -> DOWN, counter restored to 0, no long pulse re-arm; key_s=1 and counter=DEB_CNT-1 -> IDLE; otherwise counter+1.
REQ-016 key_state SHALL be registered, 1 in DOWN and REL_FILT, 0 otherwise.
REQ-017 key_press SHALL assert for exactly one cycle, the cycle after the PRESS_FILT->DOWN transition, coincident with key_state rising.
REQ-018 key_release SHALL assert for exactly one cycle, the cycle after the REL_FILT->IDLE transition, coincident with key_state falling.
REQ-019 Any bounce shorter than DEB_CNT cycles SHALL produce no pulse and no key_state change.
REQ-020 key_press, key_release and key_long SHALL never assert in the same cycle, and each SHALL assert at most once per press/release cycle.
REQ-021 Total press latency SHALL be 2 (synchronizer) + DEB_CNT + 1 cycles from the first stable low on key_in to key_press.
REQ-022 Parameters SHALL satisfy DEB_CNT>=2 and LONG_CNT>DEB_CNT; other values are unsupported.

Reset
REQ-023 With rst_n=0, the FSM SHALL be IDLE, counter=0, synchronizer flops=1, and key_state, key_press, key_release and key_long=0, all asynchronously.
REQ-024 Reset asserted mid-press SHALL emit no key_release; after release, a still-held key SHALL be re-debounced from IDLE and emit key_press.

Configuration
REQ-025 With macro KEY_LONG_PRESS_EN defined, key_long SHALL pulse once, one cycle after the DOWN counter first reaches LONG_CNT-1; a REL_FILT bounce back to DOWN restarts the hold count.
REQ-026 Without KEY_LONG_PRESS_EN, the key_long port SHALL remain present, tied to 0, with no long-press logic and DOWN counter saturation at DEB_CNT-1.

Verification (DEB_CNT=8, LONG_CNT=32, 20 ns clk)
REQ-027 rst_n low for 1000 ns, key_in=1 -> all outputs 0 throughout; after release, outputs remain 0 for 100 cycles.
REQ-028 key_in falls and stays low -> key_press pulses 1 cycle at edge+11 cycles; key_state=1 from the same cycle.
REQ-029 key_in low glitches of 1, 3 and 7 cycles, each separated by 2 high cycles -> no key_press, key_state stays 0.
REQ-030 Clean press then release after 20 cycles, with a 3-cycle high bounce before the final release -> exactly 1 key_press, 1 key_release, and key_state falls 11 cycles after the final stable high.
REQ-031 KEY_LONG_PRESS_EN defined, key held 60 cycles -> exactly 1 key_long pulse, 32 cycles after key_press; without the macro -> key_long stays 0.
REQ-032 rst_n pulsed low while key_state=1 and key held -> key_state drops immediately, no key_release, and key_press re-occurs 11 cycles after rst_n rises.
